// File: rtl/ticket_pkg.sv
// rtl/ticket_pkg.sv - shared states, coin values and default prices for the ticket vending controller
package ticket_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAY      = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_e;

  localparam logic [7:0] COIN1  = 8'd1;
  localparam logic [7:0] COIN5  = 8'd5;
  localparam logic [7:0] COIN10 = 8'd10;

  localparam int unsigned PRICE0_DEF    = 2;
  localparam int unsigned PRICE1_DEF    = 3;
  localparam int unsigned PRICE2_DEF    = 5;
  localparam int unsigned PRICE3_DEF    = 7;
  localparam int unsigned MONEY_MAX_DEF = 99;

  // Value of all coins pulsed on one edge; all three together add 16.
  function automatic logic [7:0] coin_sum(input logic c1, input logic c5, input logic c10);
    return (c1 ? COIN1 : 8'd0) + (c5 ? COIN5 : 8'd0) + (c10 ? COIN10 : 8'd0);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - per-bit two-flop synchroniser with registered rising-edge pulse
module btn_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] pulse_o
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;
  logic [W-1:0] prev_q;
  logic [W-1:0] pulse_q;

  // Synchronise, remember the last synchronised level, and register a one-cycle pulse on 0->1.
  // Clearing prev_q in reset means a button held through reset release still yields one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ticket_vend_ctrl.sv
// rtl/ticket_vend_ctrl.sv - ticket selection, payment, dispense and refund state machine
module ticket_vend_ctrl
  import ticket_pkg::*;
#(
  parameter int unsigned PRICE0      = PRICE0_DEF,
  parameter int unsigned PRICE1      = PRICE1_DEF,
  parameter int unsigned PRICE2      = PRICE2_DEF,
  parameter int unsigned PRICE3      = PRICE3_DEF,
  parameter int unsigned MONEY_MAX   = MONEY_MAX_DEF,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_type,
  input  logic       btn_count,
  input  logic       btn_coin1,
  input  logic       btn_coin5,
  input  logic       btn_coin10,
  input  logic       btn_cancel,
  output logic [7:0] money,
  output logic [7:0] moneyReturn,
  output logic [1:0] ticketType,
  output logic [1:0] ticketCount,
  output logic       ticket_out,
  output logic       busy
);

  localparam int unsigned    CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic [5:0]    pulse;
  logic          p_type, p_count, p_coin1, p_coin5, p_coin10, p_cancel, p_coin_any;
  logic [7:0]    coins;
  logic [7:0]    price;
  logic [7:0]    total;
  logic [8:0]    money_add;
  logic [7:0]    money_sat;
  logic [1:0]    count_next;

  state_e        state_q;
  logic [7:0]    money_q;
  logic [7:0]    money_ret_q;
  logic [1:0]    ticket_type_q;
  logic [1:0]    ticket_count_q;
  logic          ticket_out_q;
  logic [CW-1:0] hold_q;
  logic [CW-1:0] hold_d;

  btn_edge #(.W(6)) u_btn_edge (
    .clk     (clk),
    .rst     (rst),
    .btn_i   ({btn_cancel, btn_coin10, btn_coin5, btn_coin1, btn_count, btn_type}),
    .pulse_o (pulse)
  );

  assign p_type     = pulse[0];
  assign p_count    = pulse[1];
  assign p_coin1    = pulse[2];
  assign p_coin5    = pulse[3];
  assign p_coin10   = pulse[4];
  assign p_cancel   = pulse[5];
  assign p_coin_any = p_coin1 | p_coin5 | p_coin10;
  assign coins      = coin_sum(p_coin1, p_coin5, p_coin10);

  // Price of the currently selected ticket type.
  always_comb begin
    price = 8'(PRICE0);
    case (ticket_type_q)
      2'd1:    price = 8'(PRICE1);
      2'd2:    price = 8'(PRICE2);
      2'd3:    price = 8'(PRICE3);
      default: price = 8'(PRICE0);
    endcase
  end

  assign total      = price * {6'd0, ticket_count_q};
  assign money_add  = {1'b0, money_q} + {1'b0, coins};
  assign money_sat  = (money_add > 9'(MONEY_MAX)) ? 8'(MONEY_MAX) : money_add[7:0];
  assign count_next = (ticket_count_q == 2'd3) ? 2'd1 : ticket_count_q + 2'd1;
  assign hold_d     = hold_q + CW'(1);

  // Main controller: selection in IDLE, payment with cancel > sufficiency > coins, timed hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      money_q        <= 8'd0;
      money_ret_q    <= 8'd0;
      ticket_type_q  <= 2'd0;
      ticket_count_q <= 2'd1;
      ticket_out_q   <= 1'b0;
      hold_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p_cancel) begin
            ticket_type_q  <= 2'd0;
            ticket_count_q <= 2'd1;
          end else begin
            if (p_type)  ticket_type_q  <= ticket_type_q + 2'd1;
            if (p_count) ticket_count_q <= count_next;
          end
          if (p_coin_any) begin
            money_q <= coins;
            state_q <= PAY;
          end
        end
        PAY: begin
          if (p_cancel) begin
            money_ret_q <= money_q;
            money_q     <= 8'd0;
            hold_q      <= '0;
            state_q     <= REFUND;
          end else if (money_q >= total) begin
            money_ret_q  <= money_q - total;
            ticket_out_q <= 1'b1;
            hold_q       <= '0;
            state_q      <= DISPENSE;
          end else if (p_coin_any) begin
            money_q <= money_sat;
          end
        end
        DISPENSE, REFUND: begin
          if (hold_q == HOLD_LAST) begin
            money_q      <= 8'd0;
            money_ret_q  <= 8'd0;
            ticket_out_q <= 1'b0;
            hold_q       <= '0;
            state_q      <= IDLE;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign money       = money_q;
  assign moneyReturn = money_ret_q;
  assign ticketType  = ticket_type_q;
  assign ticketCount = ticket_count_q;
  assign ticket_out  = ticket_out_q;
  assign busy        = (state_q == DISPENSE) || (state_q == REFUND);

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// tb/tb_ticket_vend_ctrl.sv - directed self-checking bench for ticket_vend_ctrl
module tb_ticket_vend_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_type = 1'b0, btn_count = 1'b0, btn_coin1 = 1'b0;
  logic btn_coin5 = 1'b0, btn_coin10 = 1'b0, btn_cancel = 1'b0;

  logic [7:0] money, money_ret;
  logic [1:0] t_type, t_count;
  logic       t_out, busy;

  logic [7:0] money50, money_ret50;
  logic [1:0] t_type50, t_count50;
  logic       t_out50, busy50;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [5:0] B_TYPE   = 6'b000001;
  localparam logic [5:0] B_COUNT  = 6'b000010;
  localparam logic [5:0] B_C1     = 6'b000100;
  localparam logic [5:0] B_C5     = 6'b001000;
  localparam logic [5:0] B_C10    = 6'b010000;
  localparam logic [5:0] B_CANCEL = 6'b100000;

  always #5 clk = ~clk;

  ticket_vend_ctrl #(.HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .btn_type(btn_type), .btn_count(btn_count), .btn_coin1(btn_coin1),
    .btn_coin5(btn_coin5), .btn_coin10(btn_coin10), .btn_cancel(btn_cancel),
    .money(money), .moneyReturn(money_ret), .ticketType(t_type),
    .ticketCount(t_count), .ticket_out(t_out), .busy(busy)
  );

  ticket_vend_ctrl #(.PRICE3(50), .HOLD_CYCLES(8)) dut50 (
    .clk(clk), .rst(rst),
    .btn_type(btn_type), .btn_count(btn_count), .btn_coin1(btn_coin1),
    .btn_coin5(btn_coin5), .btn_coin10(btn_coin10), .btn_cancel(btn_cancel),
    .money(money50), .moneyReturn(money_ret50), .ticketType(t_type50),
    .ticketCount(t_count50), .ticket_out(t_out50), .busy(busy50)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [5:0] m);
    {btn_cancel, btn_coin10, btn_coin5, btn_coin1, btn_count, btn_type} = m;
  endtask

  // One-cycle press; on return the controller has acted on it (edge k+3).
  task automatic press(input logic [5:0] m);
    set_btn(m);
    tick();
    set_btn(6'b0);
    tick();
    tick();
    tick();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    // Reset state
    ticks(2);
    rst = 1'b0;
    tick();
    chk("rst_money", money, 8'd0);
    chk("rst_ret", money_ret, 8'd0);
    chk("rst_type", {6'd0, t_type}, 8'd0);
    chk("rst_count", {6'd0, t_count}, 8'd1);
    chk("rst_tout", {7'd0, t_out}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);

    // Selection latency: change appears exactly at edge k+3
    set_btn(B_TYPE);
    tick();
    set_btn(6'b0);
    tick();
    tick();
    chk("lat_type_k2", {6'd0, t_type}, 8'd0);
    tick();
    chk("lat_type_k3", {6'd0, t_type}, 8'd1);
    press(B_TYPE);
    chk("sel_type2", {6'd0, t_type}, 8'd2);
    press(B_COUNT);
    chk("sel_count2", {6'd0, t_count}, 8'd2);
    chk("sel_money0", money, 8'd0);
    chk("sel_idle", {7'd0, busy}, 8'd0);

    // Type wraps 3->0, then select type 1, count 2: total 6
    press(B_TYPE);
    press(B_TYPE);
    chk("type_wrap", {6'd0, t_type}, 8'd0);
    press(B_TYPE);
    press(B_C5);
    chk("pay_m5", money, 8'd5);
    chk("pay_notbusy", {7'd0, busy}, 8'd0);
    press(B_C5);
    chk("pay_m10", money, 8'd10);
    chk("pay_tout0", {7'd0, t_out}, 8'd0);
    tick();
    chk("disp_ret", money_ret, 8'd4);
    chk("disp_tout", {7'd0, t_out}, 8'd1);
    chk("disp_busy", {7'd0, busy}, 8'd1);
    chk("disp_money", money, 8'd10);
    ticks(7);
    chk("disp_busy7", {7'd0, busy}, 8'd1);
    tick();
    chk("disp_end_busy", {7'd0, busy}, 8'd0);
    chk("disp_end_money", money, 8'd0);
    chk("disp_end_ret", money_ret, 8'd0);
    chk("disp_end_tout", {7'd0, t_out}, 8'd0);
    chk("disp_keep_type", {6'd0, t_type}, 8'd1);
    chk("disp_keep_count", {6'd0, t_count}, 8'd2);

    // Refund: type 2, count 3 (total 15), money 11, cancel
    press(B_TYPE);
    press(B_COUNT);
    press(B_C10);
    press(B_C1);
    chk("ref_m11", money, 8'd11);
    press(B_CANCEL);
    chk("ref_ret", money_ret, 8'd11);
    chk("ref_money", money, 8'd0);
    chk("ref_busy", {7'd0, busy}, 8'd1);
    chk("ref_tout", {7'd0, t_out}, 8'd0);
    ticks(7);
    chk("ref_busy7", {7'd0, busy}, 8'd1);
    tick();
    chk("ref_end_busy", {7'd0, busy}, 8'd0);
    chk("ref_end_ret", money_ret, 8'd0);
    chk("ref_keep_type", {6'd0, t_type}, 8'd2);
    chk("ref_keep_count", {6'd0, t_count}, 8'd3);

    // Simultaneous coins, then cancel with a coin: type 3, count 3 (total 21)
    press(B_TYPE);
    press(B_C1);
    chk("sim_m1", money, 8'd1);
    press(B_C1 | B_C10);
    chk("sim_m12", money, 8'd12);
    press(B_CANCEL | B_C5);
    chk("sim_ret12", money_ret, 8'd12);
    chk("sim_money0", money, 8'd0);
    chk("sim_busy", {7'd0, busy}, 8'd1);
    ticks(8);
    chk("sim_end_busy", {7'd0, busy}, 8'd0);

    // Saturation on the PRICE3=50 instance: total 150, ten coin10 presses
    for (int i = 0; i < 9; i++) press(B_C10);
    chk("sat_m90", money50, 8'd90);
    press(B_C10);
    chk("sat_m99", money50, 8'd99);
    chk("sat_tout", {7'd0, t_out50}, 8'd0);
    chk("sat_busy", {7'd0, busy50}, 8'd0);
    press(B_CANCEL);
    chk("sat_ret99", money_ret50, 8'd99);
    chk("sat_money0", money50, 8'd0);

    // Reset mid-hold: type 1 (price 3), coin5 dispenses with change 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    press(B_TYPE);
    press(B_C5);
    tick();
    chk("mh_tout", {7'd0, t_out}, 8'd1);
    chk("mh_ret", money_ret, 8'd2);
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mh_money", money, 8'd0);
    chk("mh_ret0", money_ret, 8'd0);
    chk("mh_type", {6'd0, t_type}, 8'd0);
    chk("mh_count", {6'd0, t_count}, 8'd1);
    chk("mh_tout0", {7'd0, t_out}, 8'd0);
    chk("mh_busy0", {7'd0, busy}, 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
